// File: rtl/minhash_min_accumulator.sv
// Running per-seed minimum over one sequence of MinHash signature beats.
// The finished sketch and k-mer count are held on a valid/ready port until taken.
module minhash_min_accumulator #(
   parameter int HASHER_DATA_BITS = 32,
   parameter int NUM_HASHES       = 4,
   parameter int COUNT_BITS       = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_HASHES*HASHER_DATA_BITS-1:0] sig_in,
   input  logic                                   sig_valid,
   input  logic                                   sig_last,
   output logic                                   sig_ready,
   output logic [NUM_HASHES*HASHER_DATA_BITS-1:0] sketch_out,
   output logic [COUNT_BITS-1:0]                  kmer_count,
   output logic                                   sketch_valid,
   input  logic                                   sketch_ready
);

   localparam int W  = HASHER_DATA_BITS;
   localparam int SW = NUM_HASHES * HASHER_DATA_BITS;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t                state;
   logic [SW-1:0]         min_q;
   logic [SW-1:0]         min_next;
   logic [COUNT_BITS-1:0] count_q;
   logic [COUNT_BITS-1:0] count_next;
   logic                  in_accept;
   logic                  out_accept;

   assign in_accept  = sig_valid & sig_ready;
   assign out_accept = sketch_valid & sketch_ready;

   // Strict less-than so ties keep the stored value; EMPTY holds all-ones,
   // so the first beat of a sequence loads through the same comparison.
   always_comb begin
      min_next = min_q;
      for (int i = 0; i < NUM_HASHES; i++) begin
         if (sig_in[i*W +: W] < min_q[i*W +: W]) begin
            min_next[i*W +: W] = sig_in[i*W +: W];
         end
      end
   end

   assign count_next = (count_q == {COUNT_BITS{1'b1}}) ? count_q
                                                        : count_q + COUNT_BITS'(1);

   // sig_ready and sketch_valid are registered copies of the next state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_EMPTY;
         min_q        <= {SW{1'b1}};
         count_q      <= '0;
         sketch_valid <= 1'b0;
         sig_ready    <= 1'b1;
      end else begin
         case (state)
            S_EMPTY, S_ACCUM: begin
               if (in_accept) begin
                  min_q   <= min_next;
                  count_q <= count_next;
                  if (sig_last) begin
                     state        <= S_DONE;
                     sketch_valid <= 1'b1;
                     sig_ready    <= 1'b0;
                  end else begin
                     state <= S_ACCUM;
                  end
               end
            end
            S_DONE: begin
               if (out_accept) begin
                  state        <= S_EMPTY;
                  min_q        <= {SW{1'b1}};
                  count_q      <= '0;
                  sketch_valid <= 1'b0;
                  sig_ready    <= 1'b1;
               end
            end
            default: begin
               state        <= S_EMPTY;
               min_q        <= {SW{1'b1}};
               count_q      <= '0;
               sketch_valid <= 1'b0;
               sig_ready    <= 1'b1;
            end
         endcase
      end
   end

   assign sketch_out = min_q;
   assign kmer_count = count_q;

endmodule

// File: tb/tb_minhash_min_accumulator.sv
// Scoreboard bench: the driver records accepted beats into a reference sequence model,
// and a monitor compares every sketch handed over on the output port.
module tb_minhash_min_accumulator;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int CB = 4;
   localparam int SW = N * W;

   typedef logic [SW-1:0] vec_t;
   typedef struct {
      vec_t          sketch;
      logic [CB-1:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   vec_t          sig_in = '0;
   logic          sig_valid = 1'b0;
   logic          sig_last = 1'b0;
   logic          sig_ready;
   vec_t          sketch_out;
   logic [CB-1:0] kmer_count;
   logic          sketch_valid;
   logic          sketch_ready = 1'b1;

   int   checks = 0;
   int   errors = 0;
   bit   rand_ready = 1'b0;
   vec_t seq_q[$];
   exp_t exp_q[$];
   exp_t mon_e;
   exp_t bp_e;
   bit   ok;

   minhash_min_accumulator #(
      .HASHER_DATA_BITS(W),
      .NUM_HASHES(N),
      .COUNT_BITS(CB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sig_in(sig_in),
      .sig_valid(sig_valid),
      .sig_last(sig_last),
      .sig_ready(sig_ready),
      .sketch_out(sketch_out),
      .kmer_count(kmer_count),
      .sketch_valid(sketch_valid),
      .sketch_ready(sketch_ready)
   );

   always #5 clk = ~clk;

   function automatic vec_t pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input logic [W-1:0] d);
      return {d, c, b, a};
   endfunction

   // Reference: each lane's sketch is the smallest value seen in the sequence
   // (all-ones if none smaller), count is the number of beats capped at 2^CB-1.
   function automatic exp_t modelSequence();
      exp_t   r;
      longint cap;
      for (int i = 0; i < N; i++) begin
         logic [W-1:0] m;
         m = '1;
         foreach (seq_q[k]) begin
            if (seq_q[k][i*W +: W] < m) m = seq_q[k][i*W +: W];
         end
         r.sketch[i*W +: W] = m;
      end
      cap = (longint'(1) << CB) - 1;
      r.cnt = (seq_q.size() > cap) ? CB'(cap) : CB'(seq_q.size());
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic randomizeReady();
      if (rand_ready) sketch_ready = 1'($urandom_range(0, 1));
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic applyStimulus(input vec_t data, input logic last, output bit accepted);
      sig_in    = data;
      sig_last  = last;
      sig_valid = 1'b1;
      accepted  = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (sig_ready) begin
            accepted = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         randomizeReady();
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: sig_ready stayed %b, required 1", sig_ready);
      end else begin
         @(posedge clk);
         #1;
         seq_q.push_back(data);
         if (last) begin
            exp_q.push_back(modelSequence());
            seq_q.delete();
         end
         randomizeReady();
      end
      sig_valid = 1'b0;
      sig_last  = 1'b0;
   endtask

   task automatic idleCycle();
      sig_valid = 1'b0;
      sig_in    = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      randomizeReady();
   endtask

   // Asserts reset between edges and checks outputs respond without a clock.
   task automatic pulseReset(input string tag);
      #3;
      rst = 1'b1;
      #1;
      checkOutput({tag, "_sketch"}, sketch_out, {SW{1'b1}});
      checkOutput({tag, "_count"}, SW'(kmer_count), '0);
      checkOutput({tag, "_valid"}, SW'(sketch_valid), '0);
      checkOutput({tag, "_ready"}, SW'(sig_ready), SW'(1));
      #2;
      rst = 1'b0;
      seq_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] randLane();
      case ($urandom_range(0, 3))
         0:       return W'($urandom_range(0, 7));
         1:       return '1;
         default: return W'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst && sketch_valid && sketch_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_sketch: got sketch %h count %0d, required no output", sketch_out, kmer_count);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("sketch", sketch_out, mon_e.sketch);
            checkOutput("count", SW'(kmer_count), SW'(mon_e.cnt));
         end
      end
   end

   initial begin
      #1 rst = 1'b1;
      #2;
      checkOutput("reset_sketch", sketch_out, {SW{1'b1}});
      checkOutput("reset_count", SW'(kmer_count), '0);
      checkOutput("reset_valid", SW'(sketch_valid), '0);
      checkOutput("reset_ready", SW'(sig_ready), SW'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic minimum
      applyStimulus(pack(5, 9, 32'h10, 7), 1'b0, ok);
      applyStimulus(pack(3, 9, 32'h20, 8), 1'b0, ok);
      applyStimulus(pack(4, 1, 32'h08, 7), 1'b1, ok);
      @(negedge clk);
      checkOutput("basic_valid", SW'(sketch_valid), SW'(1));
      checkOutput("basic_sketch", sketch_out, pack(3, 1, 32'h08, 7));
      checkOutput("basic_count", SW'(kmer_count), SW'(3));
      @(negedge clk);
      checkOutput("basic_valid_drop", SW'(sketch_valid), '0);
      checkOutput("basic_ready_back", SW'(sig_ready), SW'(1));
      @(posedge clk);
      #1;

      // Single-beat sequence
      applyStimulus(pack(32'hFFFFFFFF, 0, 32'h12345678, 32'hFFFFFFFE), 1'b1, ok);
      idleCycle();

      // Ties and gaps
      applyStimulus(pack(5, 5, 5, 5), 1'b0, ok);
      idleCycle();
      applyStimulus(pack(5, 6, 4, 5), 1'b0, ok);
      idleCycle();
      applyStimulus(pack(5, 5, 5, 5), 1'b1, ok);
      idleCycle();

      // Backpressure with a beat held upstream
      sketch_ready = 1'b0;
      applyStimulus(pack(10, 20, 30, 40), 1'b0, ok);
      applyStimulus(pack(15, 5, 35, 1), 1'b1, ok);
      bp_e      = exp_q[$];
      sig_in    = pack(7, 7, 7, 7);
      sig_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bp_ready", SW'(sig_ready), '0);
         checkOutput("bp_sketch", sketch_out, bp_e.sketch);
         checkOutput("bp_count", SW'(kmer_count), SW'(bp_e.cnt));
         @(posedge clk);
         #1;
      end
      sketch_ready = 1'b1;
      applyStimulus(pack(7, 7, 7, 7), 1'b0, ok);
      checkOutput("bp_held_count", SW'(kmer_count), SW'(1));
      checkOutput("bp_held_sketch", sketch_out, pack(7, 7, 7, 7));
      applyStimulus(pack(9, 2, 9, 9), 1'b1, ok);
      idleCycle();

      // Count saturation
      for (int b = 0; b < 20; b++) applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, ok);
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1, ok);
      idleCycle();

      // Reset mid-sequence, then during DONE
      applyStimulus(pack(1, 2, 3, 4), 1'b0, ok);
      applyStimulus(pack(0, 0, 0, 0), 1'b0, ok);
      pulseReset("rst_mid");
      applyStimulus(pack(100, 200, 300, 400), 1'b0, ok);
      sketch_ready = 1'b0;
      applyStimulus(pack(50, 250, 350, 450), 1'b1, ok);
      pulseReset("rst_done");
      sketch_ready = 1'b1;
      applyStimulus(pack(60, 70, 80, 90), 1'b0, ok);
      applyStimulus(pack(65, 60, 85, 95), 1'b1, ok);
      idleCycle();

      // Randomized sequences with random output backpressure
      rand_ready = 1'b1;
      for (int s = 0; s < 30; s++) begin
         int len;
         len = $urandom_range(1, 7);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idleCycle();
            applyStimulus(pack(randLane(), randLane(), randLane(), randLane()), 1'(b == len - 1), ok);
         end
      end
      rand_ready   = 1'b0;
      sketch_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) idleCycle();
      checkOutput("queue_drained", SW'(exp_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
